alu_issue_ctrl: RTL and testbench

Initiator-side controller for the 8-bit ALU operand/command interface. Accepts operation requests (a, b, command) through a valid/ready port, queues them in a small FIFO, and drives the ALU's `a`, `b`, `command` and `oe` inputs one operation at a time. After a settle interval it samples the ALU's 16-bit `y` and returns it on a valid/ready result port. It sits between the instruction-decode stage and the combinational ALU.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, request record and controller state encoding for the
// ALU operand/command interface.
package alu_pkg;

  localparam int ALU_W     = 8;
  localparam int ALU_Y_W   = 16;
  localparam int ALU_CMD_W = 4;

  localparam logic [ALU_CMD_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CMD_W-1:0] ALU_SUB = 4'b0010;
  localparam logic [ALU_CMD_W-1:0] ALU_SHR = 4'b0111;
  localparam logic [ALU_CMD_W-1:0] ALU_BUF = 4'b1111;

  // ST_ prefix keeps the literals clear of the SETTLE parameter name.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } alu_state_e;

  // One queued request, packed as {cmd, a, b} (20 bits).
  typedef struct packed {
    logic [ALU_CMD_W-1:0] cmd;
    logic [ALU_W-1:0]     a;
    logic [ALU_W-1:0]     b;
  } alu_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. Pointers carry one extra bit
// so full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             wr_fire;
  logic             rd_fire;

  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  // Head entry is visible without a read cycle so the consumer can pop and
  // use it in the same edge.
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  // Pointer advance on accepted write/read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues queued ALU requests one at a time, holds operands for SETTLE cycles,
// then captures the ALU result and offers it on a valid/ready port.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ALU_W-1:0]        in_a,
  input  logic [ALU_W-1:0]        in_b,
  input  logic [ALU_CMD_W-1:0]    in_cmd,
  output logic [ALU_W-1:0]        alu_a,
  output logic [ALU_W-1:0]        alu_b,
  output logic [ALU_CMD_W-1:0]    alu_cmd,
  output logic                    alu_oe,
  input  logic [ALU_Y_W-1:0]      alu_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ALU_Y_W-1:0]      out_y,
  output logic [ALU_CMD_W-1:0]    out_cmd,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  alu_state_e  state_reg;
  logic [CW-1:0] cnt_reg;
  alu_req_t    push_req;
  alu_req_t    head_req;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;

  assign push_req = '{cmd: in_cmd, a: in_a, b: in_b};
  assign in_ready = !fifo_full;
  assign busy     = (state_reg != ST_IDLE) || !fifo_empty;
  // A pop happens when idle, or when the held result is being consumed.
  assign pop = !fifo_empty &&
               ((state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && out_ready));

  sync_fifo #(
    .WIDTH ($bits(alu_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid && in_ready),
    .wr_data (push_req),
    .rd_en   (pop),
    .rd_data (head_req),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Issue / settle / hold sequencing and output capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cmd   <= '0;
      alu_oe    <= 1'b0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_cmd   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            alu_a     <= head_req.a;
            alu_b     <= head_req.b;
            alu_cmd   <= head_req.cmd;
            alu_oe    <= 1'b1;
            cnt_reg   <= CW'(SETTLE - 1);
            state_reg <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
          end else begin
            out_y     <= alu_y;
            out_cmd   <= alu_cmd;
            out_valid <= 1'b1;
            alu_oe    <= 1'b0;
            state_reg <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pop) begin
              // Back-to-back issue straight from the consumed result.
              alu_a     <= head_req.a;
              alu_b     <= head_req.b;
              alu_cmd   <= head_req.cmd;
              alu_oe    <= 1'b1;
              cnt_reg   <= CW'(SETTLE - 1);
              state_reg <= ST_SETTLE;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU on each instance.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // SETTLE=1 instance
  logic        in_valid = 1'b0, in_ready;
  logic [7:0]  in_a = '0, in_b = '0;
  logic [3:0]  in_cmd = '0;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_oe;
  logic [15:0] alu_y;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out_y;
  logic [3:0]  out_cmd;
  logic [2:0]  level;
  logic        busy;

  // SETTLE=3 instance
  logic        in_valid3 = 1'b0, in_ready3;
  logic [7:0]  in_a3 = '0, in_b3 = '0;
  logic [3:0]  in_cmd3 = '0;
  logic [7:0]  alu_a3, alu_b3;
  logic [3:0]  alu_cmd3;
  logic        alu_oe3;
  logic [15:0] alu_y3;
  logic        out_valid3, out_ready3 = 1'b0;
  logic [15:0] out_y3;
  logic [3:0]  out_cmd3;
  logic [2:0]  level3;
  logic        busy3;

  logic [19:0] sb [$];
  int          hs_cyc [$];
  int          acc_cnt = 0;
  logic [3:0]  cmds [5] = '{ALU_ADD, ALU_SUB, ALU_SHR, ALU_BUF, 4'h9};
  logic [46:0] rst_exp;
  logic [46:0] rst_obs;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] c);
    case (c)
      ALU_ADD: return {8'h00, a} + {8'h00, b};
      ALU_SUB: return {8'h00, a} - {8'h00, b};
      ALU_SHR: return {8'h00, a >> b[2:0]};
      ALU_BUF: return {8'h00, a};
      default: return {a, b};
    endcase
  endfunction

  assign alu_y  = alu_oe  ? alu_f(alu_a,  alu_b,  alu_cmd)  : 16'hDEAD;
  assign alu_y3 = alu_oe3 ? alu_f(alu_a3, alu_b3, alu_cmd3) : 16'hDEAD;

  alu_issue_ctrl #(.DEPTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cmd(in_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_oe(alu_oe), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_cmd(out_cmd),
    .level(level), .busy(busy)
  );

  alu_issue_ctrl #(.DEPTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_a(in_a3), .in_b(in_b3), .in_cmd(in_cmd3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_cmd(alu_cmd3), .alu_oe(alu_oe3), .alu_y(alu_y3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_y(out_y3), .out_cmd(out_cmd3),
    .level(level3), .busy(busy3)
  );

  // Scoreboard: push expected on accepted request, compare on result handshake.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      sb.push_back({in_cmd, alu_f(in_a, in_b, in_cmd)});
      acc_cnt++;
    end
    if (!rst && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      $display("result cyc=%0d cmd=%h y=%h", cyc, out_cmd, out_y);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got cmd=%h y=%h, required none", out_cmd, out_y);
      end else begin
        logic [19:0] exp;
        exp = sb.pop_front();
        if ({out_cmd, out_y} !== exp) begin
          errors++;
          $display("FAIL result_order: got cmd=%h y=%h, required cmd=%h y=%h",
                   out_cmd, out_y, exp[19:16], exp[15:0]);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_cmd = c;
  endtask

  task automatic release_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    i = 0;
    while ((sb.size() != 0 || busy) && i < 200) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (i >= 200) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending busy=%b, required 0 pending busy=0",
               name, sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    rst_obs = {level, in_ready, alu_a, alu_b, alu_cmd, alu_oe, out_valid, out_y, out_cmd, busy};
    checks++;
    if (rst_obs !== rst_exp) begin
      errors++;
      $display("FAIL reset_s1: got %h, required %h", rst_obs, rst_exp);
    end
    rst_obs = {level3, in_ready3, alu_a3, alu_b3, alu_cmd3, alu_oe3, out_valid3, out_y3,
               out_cmd3, busy3};
    checks++;
    if (rst_obs !== rst_exp) begin
      errors++;
      $display("FAIL reset_s3: got %h, required %h", rst_obs, rst_exp);
    end
  endtask

  task automatic test_single_add();
    int n, got, oe_n;
    logic [15:0] y;
    logic [3:0]  c;
    out_ready = 1'b1;
    got = -1; oe_n = 0; y = '0; c = '1;
    drive(8'h0A, 8'h05, ALU_ADD);
    n = cyc;
    release_in();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_oe) oe_n++;
      if (out_valid && got < 0) begin got = cyc; y = out_y; c = out_cmd; end
    end
    checks++;
    if (got !== n + 3) begin
      errors++; $display("FAIL add_latency: got cycle %0d, required %0d", got, n + 3);
    end
    checks++;
    if (oe_n !== 1) begin
      errors++; $display("FAIL add_oe_len: got %0d, required 1", oe_n);
    end
    checks++;
    if ({c, y} !== {4'b0000, 16'h000F}) begin
      errors++; $display("FAIL add_value: got cmd=%h y=%h, required cmd=0 y=000f", c, y);
    end
    wait_drain("add");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    hs_cyc.delete();
    drive(8'h0A, 8'h05, ALU_ADD);
    drive(8'h0A, 8'h05, ALU_SUB);
    release_in();
    wait_drain("b2b");
    checks++;
    if (hs_cyc.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d, required 2", hs_cyc.size());
    end else begin
      checks++;
      if (hs_cyc[1] - hs_cyc[0] != 2) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d, required 2", hs_cyc[1] - hs_cyc[0]);
      end
    end
  endtask

  task automatic test_full();
    int start, idx;
    logic [15:0] y0;
    bit have;
    have = 1'b0; y0 = '0;
    out_ready = 1'b0;
    hs_cyc.delete();
    start = acc_cnt;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      idx = acc_cnt - start;
      in_valid = 1'b1;
      in_a = 8'(16 + idx * 3);
      in_b = 8'(3 + idx);
      in_cmd = cmds[idx % 5];
      @(negedge clk);
      if (out_valid && !have) begin have = 1'b1; y0 = out_y; end
    end
    checks++;
    if (acc_cnt - start != 5) begin
      errors++; $display("FAIL full_accepts: got %0d, required 5", acc_cnt - start);
    end
    checks++;
    if (in_ready !== 1'b0 || level !== 3'd4) begin
      errors++;
      $display("FAIL full_state: got in_ready=%b level=%0d, required 0 4", in_ready, level);
    end
    checks++;
    if (!have || out_valid !== 1'b1 || out_y !== y0) begin
      errors++;
      $display("FAIL full_hold_stable: got valid=%b y=%h, required 1 %h", out_valid, out_y, y0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("full");
    checks++;
    if (hs_cyc.size() != 5) begin
      errors++; $display("FAIL full_results: got %0d, required 5", hs_cyc.size());
    end
  endtask

  task automatic test_simul();
    out_ready = 1'b0;
    drive(8'h11, 8'h22, ALU_ADD);
    drive(8'h40, 8'h01, ALU_SUB);
    drive(8'h80, 8'h03, ALU_SHR);
    release_in();
    repeat (4) @(negedge clk);
    checks++;
    if (level !== 3'd2 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_pre: got level=%0d valid=%b, required 2 1", level, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 8'h7E; in_b = 8'h01; in_cmd = ALU_BUF;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 3'd2) begin
      errors++; $display("FAIL simul_level: got %0d, required 2", level);
    end
    wait_drain("simul");
  endtask

  task automatic test_settle3();
    int n, got, oe_n;
    logic [19:0] r;
    got = -1; oe_n = 0; r = '0;
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b1; in_a3 = 8'h21; in_b3 = 8'h02; in_cmd3 = ALU_SHR;
    n = cyc;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (alu_oe3) oe_n++;
      if (out_valid3 && got < 0) begin got = cyc; r = {out_cmd3, out_y3}; end
    end
    $display("result3 cyc=%0d cmd=%h y=%h", got, r[19:16], r[15:0]);
    checks++;
    if (got !== n + 5) begin
      errors++; $display("FAIL s3_latency: got cycle %0d, required %0d", got, n + 5);
    end
    checks++;
    if (oe_n !== 3) begin
      errors++; $display("FAIL s3_oe_len: got %0d, required 3", oe_n);
    end
    checks++;
    if (r !== {4'b0111, 16'h0008}) begin
      errors++; $display("FAIL s3_value: got %h, required 70008", r);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    out_ready = 1'b0;
    drive(8'h01, 8'h01, ALU_ADD);
    drive(8'h02, 8'h01, ALU_SUB);
    drive(8'h03, 8'h01, ALU_BUF);
    drive(8'h04, 8'h01, ALU_SHR);
    drive(8'h05, 8'h01, 4'h6);
    release_in();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    checks++;
    if (level !== 3'd3 || alu_oe !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got level=%0d oe=%b, required 3 1", level, alu_oe);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    hs_cyc.delete();
    @(negedge clk);
    rst_obs = {level, in_ready, alu_a, alu_b, alu_cmd, alu_oe, out_valid, out_y, out_cmd, busy};
    checks++;
    if (rst_obs !== rst_exp) begin
      errors++; $display("FAIL mid_reset: got %h, required %h", rst_obs, rst_exp);
    end
    out_ready = 1'b1;
    drive(8'h30, 8'h0C, ALU_ADD);
    drive(8'hC3, 8'h00, ALU_BUF);
    release_in();
    wait_drain("mid");
    repeat (5) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    checks++;
    if (hs_cyc.size() != 2 || stray != 0) begin
      errors++;
      $display("FAIL mid_stale: got %0d results %0d stray, required 2 0", hs_cyc.size(), stray);
    end
  endtask

  initial begin
    rst_exp = {3'd0, 1'b1, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b0};
    test_reset();
    test_single_add();
    test_back_to_back();
    test_full();
    test_simul();
    test_settle3();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
